mtimer: RTL and testbench
=========================

Name: mtimer

Overview:
- Memory-mapped machine timer peripheral on the peripheral bus, decoded alongside data memory and the UART.
- Keeps a 64-bit free-running mtime counter behind a programmable prescaler and compares it against a 64-bit mtimecmp.
- Drives the core's t_intr timer-interrupt input with a registered level.
- Software clears the interrupt by rewriting mtimecmp or clearing the enable bit.

Parameters:
- DW, 32, bus data width; fixed at 32, as the register map assumes 32-bit words.
- PRESC_W, 16, prescaler field width in CTRL; legal range 1..24.
- ADDRW, 5, byte-address bits decoded from the bus.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; asynchronous and active-low.
- cs  input  1  chip select from the peripheral bus address decode.
- we  input  1  write strobe; qualified by cs.
- addr_i  input  ADDRW  byte address; bits [4:2] select the register, bits [1:0] are ignored.
- mask  input  4  byte enables for writes; bit n enables wdata_i[8n+7:8n].
- wdata_i  input  DW  write data.
- rdata_o  output  DW  read data; combinational.
- t_intr  output  1  timer interrupt; level, registered.

Behaviour:
- Register map (word offsets):
  - 0x00 MTIME_LO, RW.
  - 0x04 MTIME_HI, RW.
  - 0x08 MTIMECMP_LO, RW.
  - 0x0C MTIMECMP_HI, RW.
  - 0x10 CTRL, RW: bit0 EN; bits[8+PRESC_W-1:8] PRESC; all other bits read 0.
  - 0x14 STATUS, RO: bit0 = t_intr.
  - 0x18 and 0x1C read 0; writes to them are ignored.
- Reset (rst_i low, asynchronous):
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, EN = 0, PRESC = 0, presc_cnt = 0, t_intr = 0.
  - Reset asserted mid-count aborts the count immediately.
- Read: rdata_o = selected register when cs = 1, else 0. Reads have no side effects.
- Write: on the clock edge with cs and we high, each byte lane with mask[n] = 1 is updated; other lanes hold.
- Prescaler (presc_cnt, PRESC_W bits):
  - Counts only while EN = 1.
  - When presc_cnt == PRESC: presc_cnt <= 0 and a tick is issued; otherwise presc_cnt increments.
  - PRESC = 0 gives a tick every cycle; PRESC = N gives a tick every N+1 cycles.
  - EN = 0 freezes both presc_cnt and mtime.
  - Any write to CTRL clears presc_cnt to 0 in that cycle.
- mtime:
  - On a tick, mtime <= mtime + 1 as full 64-bit arithmetic.
  - Wraps from all-ones to 0 with no flag.
  - Carry from LO to HI is within the same cycle.
- Write/tick collision: a write to MTIME_LO or MTIME_HI in a tick cycle suppresses that increment entirely.
  - Written bytes take wdata_i; unwritten bytes hold their old value.
  - presc_cnt still advances/wraps as normal.
- Interrupt:
  - t_intr <= EN && (mtime >= mtimecmp), an unsigned 64-bit compare on current register values.
  - Latency is one cycle from the condition becoming true to t_intr = 1. Likewise, t_intr falls one cycle after a write or EN clear removes the condition.
  - Level-sensitive: t_intr stays high while the condition holds. No sticky pending bit.
- Software rule for 64-bit compare updates: write MTIMECMP_HI = all-ones first, then LO, then HI. The block provides no atomicity.
- Implementation constraints: no latches; all state in a single always_ff with asynchronous active-low reset.

Test Plan:
- Reset check: hold rst_i = 0, release, then read all registers → MTIME = 0, MTIMECMP = 0xFFFFFFFF/0xFFFFFFFF, CTRL = 0, STATUS = 0, t_intr = 0.
- Basic count with interrupt: write MTIMECMP_LO = 10, MTIMECMP_HI = 0, CTRL = 0x1 (PRESC = 0).
  - mtime reaches 10 exactly 10 cycles after the CTRL write edge.
  - t_intr rises one cycle later.
  - Writing MTIMECMP_LO = 100 drops t_intr on the next cycle.
- Prescaler: CTRL = 0x0000_0301 (PRESC = 3), run 40 cycles → mtime = 10. Clear EN, wait 20 cycles → mtime stays 10.
- Carry and wrap:
  - Write MTIME_LO = 0xFFFFFFFF, MTIME_HI = 0; one tick → LO = 0, HI = 1.
  - Write all-ones to both halves; one tick → 0/0.
- Collision and byte mask: with PRESC = 0 and EN = 1, write MTIME_LO = 0x12345678 with mask = 4'b0011 while mtime = 0x000000FF → LO = 0x00005678, with no increment in that cycle.
- Asynchronous reset mid-run: with t_intr = 1 and mtime = 500, pulse rst_i low for half a cycle → t_intr and mtime go to 0 immediately (no clock edge needed), and mtimecmp returns to all-ones.

Source files
------------

// File: rtl/mtimer_if.sv
// Peripheral-bus bundle for the machine timer.
// master drives cs/we/addr_i/mask/wdata_i and receives rdata_o;
// slave is the timer side.
//   cs      - chip select from the address decode
//   we      - write strobe, qualified by cs
//   addr_i  - byte address, [4:2] selects the register
//   mask    - byte enables for writes
//   wdata_i - write data
//   rdata_o - combinational read data (0 when not selected)
interface mtimer_if #(
   parameter int DW    = 32,
   parameter int ADDRW = 5
);
   logic             cs;
   logic             we;
   logic [ADDRW-1:0] addr_i;
   logic [3:0]       mask;
   logic [DW-1:0]    wdata_i;
   logic [DW-1:0]    rdata_o;

   modport master (output cs, we, addr_i, mask, wdata_i, input rdata_o);
   modport slave  (input cs, we, addr_i, mask, wdata_i, output rdata_o);
endinterface

// File: rtl/mtimer.sv
// Memory-mapped machine timer: 64-bit mtime behind a programmable
// prescaler, compared against 64-bit mtimecmp to drive a level interrupt.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-low reset
//   bus    - peripheral bus (mtimer_if.slave)
//   t_intr - registered timer interrupt level
// Register map (word offsets): 0x00 MTIME_LO, 0x04 MTIME_HI,
// 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL {PRESC[8+:PRESC_W], EN[0]},
// 0x14 STATUS {t_intr}, 0x18/0x1C read as zero.
module mtimer #(
   parameter int DW      = 32,
   parameter int PRESC_W = 16,
   parameter int ADDRW   = 5
) (
   input  logic    clk_i,
   input  logic    rst_i,
   mtimer_if.slave bus,
   output logic    t_intr
);
   localparam logic [2:0] A_MTIME_LO = 3'd0;
   localparam logic [2:0] A_MTIME_HI = 3'd1;
   localparam logic [2:0] A_CMP_LO   = 3'd2;
   localparam logic [2:0] A_CMP_HI   = 3'd3;
   localparam logic [2:0] A_CTRL     = 3'd4;
   localparam logic [2:0] A_STATUS   = 3'd5;

   logic [63:0]        r_mtime;
   logic [63:0]        r_mtimecmp;
   logic               r_en;
   logic [PRESC_W-1:0] r_presc;
   logic [PRESC_W-1:0] r_presc_cnt;
   logic               r_intr;

   logic [2:0]         w_sel;
   logic               w_wr;
   logic               w_tick;
   logic               w_wr_mtime;
   logic [DW-1:0]      w_ctrl;
   logic [DW-1:0]      w_ctrl_wr;
   logic [DW-1:0]      w_rdata;
   logic [63:0]        w_mtime_wr;
   logic               w_unused;

   // Byte-lane write merge: enabled lanes take the new data, others hold.
   function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_v,
                                             input logic [DW-1:0] new_v,
                                             input logic [3:0]    lanes);
      logic [DW-1:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) res[8*i +: 8] = new_v[8*i +: 8];
      end
      return res;
   endfunction

   assign w_sel      = bus.addr_i[4:2];
   assign w_wr       = bus.cs && bus.we;
   assign w_tick     = r_en && (r_presc_cnt == r_presc);
   assign w_wr_mtime = w_wr && ((w_sel == A_MTIME_LO) || (w_sel == A_MTIME_HI));
   assign w_ctrl_wr  = f_merge(w_ctrl, bus.wdata_i, bus.mask);
   assign w_unused   = &{1'b0, bus.addr_i[1:0], w_ctrl_wr};
   assign t_intr     = r_intr;
   assign bus.rdata_o = w_rdata;

   always_comb begin
      w_ctrl                = '0;
      w_ctrl[0]             = r_en;
      w_ctrl[8 +: PRESC_W]  = r_presc;
   end

   // Full 64-bit image of mtime after a software write; a write in a tick
   // cycle replaces the increment rather than combining with it.
   always_comb begin
      w_mtime_wr = r_mtime;
      if (w_sel == A_MTIME_HI)
         w_mtime_wr = {f_merge(r_mtime[63:32], bus.wdata_i, bus.mask), r_mtime[31:0]};
      else
         w_mtime_wr = {r_mtime[63:32], f_merge(r_mtime[31:0], bus.wdata_i, bus.mask)};
   end

   always_comb begin
      w_rdata = '0;
      if (bus.cs) begin
         case (w_sel)
            A_MTIME_LO: w_rdata = r_mtime[31:0];
            A_MTIME_HI: w_rdata = r_mtime[63:32];
            A_CMP_LO:   w_rdata = r_mtimecmp[31:0];
            A_CMP_HI:   w_rdata = r_mtimecmp[63:32];
            A_CTRL:     w_rdata = w_ctrl;
            A_STATUS:   w_rdata = {{(DW-1){1'b0}}, r_intr};
            default:    w_rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_mtime     <= '0;
         r_mtimecmp  <= '1;
         r_en        <= 1'b0;
         r_presc     <= '0;
         r_presc_cnt <= '0;
         r_intr      <= 1'b0;
      end else begin
         r_intr <= r_en && (r_mtime >= r_mtimecmp);

         if (r_en) r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PRESC_W'(1);

         if (w_wr_mtime)  r_mtime <= w_mtime_wr;
         else if (w_tick) r_mtime <= r_mtime + 64'd1;

         if (w_wr && (w_sel == A_CMP_LO))
            r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], bus.wdata_i, bus.mask);
         if (w_wr && (w_sel == A_CMP_HI))
            r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], bus.wdata_i, bus.mask);

         // CTRL write restarts the prescale period, overriding the count update.
         if (w_wr && (w_sel == A_CTRL)) begin
            r_en        <= w_ctrl_wr[0];
            r_presc     <= w_ctrl_wr[8 +: PRESC_W];
            r_presc_cnt <= '0;
         end
      end
   end
endmodule

// File: tb/tb_mtimer.sv
module tb_mtimer;
   logic clk = 1'b0;
   logic rst_n;
   logic t_intr;

   mtimer_if bus();

   mtimer dut (
      .clk_i  (clk),
      .rst_i  (rst_n),
      .bus    (bus),
      .t_intr (t_intr)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Reference model: architectural register state.
   logic [63:0] m_time;
   logic [63:0] m_cmp;
   bit          m_en;
   int unsigned m_presc;
   int unsigned m_cnt;
   bit          m_intr;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_time  = 64'd0;
      m_cmp   = '1;
      m_en    = 1'b0;
      m_presc = 0;
      m_cnt   = 0;
      m_intr  = 1'b0;
   endtask

   function automatic logic [31:0] put_bytes(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  lanes);
      logic [7:0] b [4];
      for (int i = 0; i < 4; i++) b[i] = lanes[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      return {b[3], b[2], b[1], b[0]};
   endfunction

   function automatic logic [31:0] ctrl_word();
      return 32'(m_presc << 8) | 32'(m_en);
   endfunction

   function automatic logic [31:0] m_read(input logic cs, input logic [4:0] a);
      if (!cs) return 32'd0;
      case (a[4:2])
         3'd0: return m_time[31:0];
         3'd1: return m_time[63:32];
         3'd2: return m_cmp[31:0];
         3'd3: return m_cmp[63:32];
         3'd4: return ctrl_word();
         3'd5: return 32'(m_intr);
         default: return 32'd0;
      endcase
   endfunction

   // One clock edge of the timer, computed from the rules on the current state.
   task automatic model_step();
      bit          wr;
      int          reg_idx;
      bit          tick;
      bit          n_intr;
      logic [63:0] n_time;
      logic [31:0] c;
      wr      = bus.cs && bus.we;
      reg_idx = int'(bus.addr_i[4:2]);
      tick    = m_en && (m_cnt == m_presc);
      n_intr  = m_en && (m_time >= m_cmp);
      n_time  = tick ? m_time + 64'd1 : m_time;
      if (m_en) m_cnt = tick ? 0 : m_cnt + 1;
      if (wr) begin
         case (reg_idx)
            0: n_time = {m_time[63:32], put_bytes(m_time[31:0], bus.wdata_i, bus.mask)};
            1: n_time = {put_bytes(m_time[63:32], bus.wdata_i, bus.mask), m_time[31:0]};
            2: m_cmp[31:0]  = put_bytes(m_cmp[31:0], bus.wdata_i, bus.mask);
            3: m_cmp[63:32] = put_bytes(m_cmp[63:32], bus.wdata_i, bus.mask);
            4: begin
               c       = put_bytes(ctrl_word(), bus.wdata_i, bus.mask);
               m_en    = c[0];
               m_presc = int'(c[23:8]);
               m_cnt   = 0;
            end
            default: ;
         endcase
      end
      m_time = n_time;
      m_intr = n_intr;
   endtask

   // Per-cycle comparison of outputs against the model.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("rdata", 64'(bus.rdata_o), 64'(m_read(bus.cs, bus.addr_i)));
         chk("t_intr", 64'(t_intr), 64'(m_intr));
      end
   end

   task automatic cycle();
      @(posedge clk);
      model_step();
      #2;
   endtask

   task automatic idle(input int n);
      bus.cs = 1'b0;
      bus.we = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m = 4'hF);
      bus.cs      = 1'b1;
      bus.we      = 1'b1;
      bus.addr_i  = a;
      bus.wdata_i = d;
      bus.mask    = m;
      cycle();
      bus.cs = 1'b0;
      bus.we = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
      bus.cs     = 1'b1;
      bus.we     = 1'b0;
      bus.addr_i = a;
      #1;
      chk(nm, 64'(bus.rdata_o), 64'(exp));
   endtask

   initial begin
      logic [31:0] reset_vals [8];
      reset_vals = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
      rst_n       = 1'b1;
      bus.cs      = 1'b0;
      bus.we      = 1'b0;
      bus.addr_i  = '0;
      bus.mask    = '0;
      bus.wdata_i = '0;
      m_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      chk_en = 1'b1;

      // Reset values of every register
      chk("reset_t_intr", 64'(t_intr), 64'd0);
      for (int i = 0; i < 8; i++) begin
         rd_chk("reset_reg", 5'(i * 4), reset_vals[i]);
         cycle();
      end

      // Basic count and interrupt
      wr(5'h08, 32'd10);
      wr(5'h0C, 32'd0);
      wr(5'h10, 32'h1);
      idle(9);
      rd_chk("count_9", 5'h00, 32'd9);
      chk("intr_before", 64'(t_intr), 64'd0);
      idle(1);
      rd_chk("count_10", 5'h00, 32'd10);
      chk("intr_lat_0", 64'(t_intr), 64'd0);
      idle(1);
      chk("intr_rise", 64'(t_intr), 64'd1);
      rd_chk("status_1", 5'h14, 32'd1);
      wr(5'h08, 32'd100);
      chk("intr_hold", 64'(t_intr), 64'd1);
      idle(1);
      chk("intr_fall", 64'(t_intr), 64'd0);

      // Prescaler 3: one tick every 4 cycles
      wr(5'h10, 32'h0);
      wr(5'h00, 32'h0);
      wr(5'h04, 32'h0);
      wr(5'h10, 32'h0000_0301);
      idle(40);
      rd_chk("presc_40", 5'h00, 32'd10);
      rd_chk("ctrl_rd", 5'h10, 32'h0000_0301);
      wr(5'h10, 32'h0000_0300);
      idle(20);
      rd_chk("frozen", 5'h00, 32'd10);

      // Carry into the high word
      wr(5'h00, 32'hFFFF_FFFF);
      wr(5'h04, 32'h0);
      wr(5'h10, 32'h1);
      idle(1);
      rd_chk("carry_lo", 5'h00, 32'd0);
      rd_chk("carry_hi", 5'h04, 32'd1);

      // 64-bit wrap
      wr(5'h10, 32'h0);
      wr(5'h00, 32'hFFFF_FFFF);
      wr(5'h04, 32'hFFFF_FFFF);
      wr(5'h10, 32'h1);
      idle(1);
      rd_chk("wrap_lo", 5'h00, 32'd0);
      rd_chk("wrap_hi", 5'h04, 32'd0);

      // Write/tick collision with partial byte mask
      wr(5'h10, 32'h0);
      wr(5'h00, 32'h0000_00FF);
      wr(5'h04, 32'h0);
      wr(5'h10, 32'h1);
      wr(5'h00, 32'h1234_5678, 4'b0011);
      rd_chk("collide_lo", 5'h00, 32'h0000_5678);
      rd_chk("collide_hi", 5'h04, 32'h0);

      // Asynchronous reset in the middle of a cycle
      wr(5'h08, 32'd400);
      wr(5'h0C, 32'd0);
      wr(5'h04, 32'd0);
      wr(5'h00, 32'd500);
      chk("pre_rst_intr", 64'(t_intr), 64'd1);
      rd_chk("pre_rst_time", 5'h00, 32'd500);
      rst_n = 1'b0;
      #1;
      chk("arst_intr", 64'(t_intr), 64'd0);
      chk("arst_time", 64'(bus.rdata_o), 64'd0);
      m_reset();
      bus.addr_i = 5'h08;
      #2;
      chk("arst_cmp", 64'(bus.rdata_o), 64'hFFFF_FFFF);
      #2 rst_n = 1'b1;
      idle(2);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int r;
         r           = int'($urandom_range(0, 99));
         bus.cs      = 1'b0;
         bus.we      = 1'b0;
         bus.addr_i  = 5'($urandom);
         bus.mask    = 4'($urandom);
         bus.wdata_i = $urandom;
         if (r < 20) begin
            bus.cs = 1'b1;
         end else if (r < 38) begin
            bus.cs = 1'b1;
            bus.we = 1'b1;
            case (bus.addr_i[4:2])
               3'd1: bus.wdata_i = $urandom_range(0, 1);
               3'd2: bus.wdata_i = m_time[31:0] + 32'($urandom_range(0, 40));
               3'd3: bus.wdata_i = m_time[63:32] + 32'($urandom_range(0, 1));
               3'd4: bus.wdata_i = {8'($urandom), 16'($urandom_range(0, 3)), 7'($urandom),
                                    1'($urandom_range(0, 4) != 0)};
               default: ;
            endcase
         end
         cycle();
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
